sync_fwft_fifo: RTL and testbench
=================================

SYNC_FWFT_FIFO -- requirements
Module: sync_fwft_fifo

Interface
REQ-001 Parameter DATA_W, default 128: data width in bits.
REQ-002 Parameter PAR_W, default 16: parity/sideband width in bits.
REQ-003 Parameter DEPTH_LOG2, default 9: capacity DEPTH = 2**DEPTH_LOG2 words, legal range 4..12.
REQ-004 Parameter PROG_FULL_OFFSET, default 16: prog_full asserts at count >= DEPTH - PROG_FULL_OFFSET; legal range 1..DEPTH-1.
REQ-005 Parameter PROG_EMPTY_THRESH, default 16: prog_empty asserts at count <= PROG_EMPTY_THRESH; legal range 0..DEPTH-1.
REQ-006 clk  in  1  sole clock; all state changes on the rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 din  in  DATA_W  write data.
REQ-009 dinp  in  PAR_W  write parity/sideband.
REQ-010 wr_en  in  1  write request.
REQ-011 rd_en  in  1  read (pop) request for the word currently on dout.
REQ-012 err_clr  in  1  synchronous clear of the sticky error flags.
REQ-013 dout  out  DATA_W  head word, first-word-fall-through (FWFT).
REQ-014 doutp  out  PAR_W  head parity, aligned with dout.
REQ-015 empty  out  1  high when dout/doutp do not hold a valid word.
REQ-016 full  out  1  high when count == DEPTH.
REQ-017 prog_full  out  1  programmable almost-full flag.
REQ-018 prog_empty  out  1  programmable almost-empty flag.
REQ-019 count  out  DEPTH_LOG2+1  words stored, including the head word.
REQ-020 overflow  out  1  sticky flag: a write was rejected.
REQ-021 underflow  out  1  sticky flag: a read was rejected.

Function
REQ-022 Storage shall be an inferred synchronous-read RAM of DEPTH words, width DATA_W+PAR_W, plus one FWFT output register; no vendor FIFO primitives.
REQ-023 A write shall be accepted iff wr_en && !full; a write with full=1 is dropped and sets overflow, even if rd_en is high in the same cycle.
REQ-024 A read shall be accepted iff rd_en && !empty; a read with empty=1 is ignored and sets underflow.
REQ-025 The first word written into an empty FIFO shall appear on dout with empty=0 after the 2nd rising edge following the accepting edge; empty is registered.
REQ-026 While a valid word is on dout and the RAM holds data, an accepted read shall present the next word on the following edge, sustaining one read per cycle without bubbles.
REQ-027 count shall increment on an accepted write only, decrement on an accepted read only, and stay unchanged when both are accepted in the same cycle.
REQ-028 full, prog_full and prog_empty shall be registered, derived from the next-state count, and update on the same edge as count.
REQ-029 When empty=1, a simultaneous wr_en and rd_en shall accept the write and reject the read, setting underflow.
REQ-030 Read and write pointers shall be DEPTH_LOG2 bits wide and wrap from DEPTH-1 to 0 with no lost or duplicated words.
REQ-031 dout and doutp shall hold their value while empty=0 and no read is accepted; their value while empty=1 is don't-care.
REQ-032 err_clr shall clear overflow and underflow on the next edge; an error event in the same cycle takes priority and leaves the flag set.
REQ-033 count may be nonzero while empty=1 during the fall-through latency; empty alone qualifies dout.

Reset
REQ-034 While rst_n=0: pointers=0, count=0, empty=1, full=0, prog_full=0, prog_empty=1, overflow=0, underflow=0, output register invalid; RAM contents are not reset.
REQ-035 Assertion of rst_n mid-operation shall discard all stored words immediately. Deassertion shall be synchronised internally, and wr_en/rd_en shall be honoured from the 2nd rising edge after rst_n rises.

Verification
REQ-036 Defaults; reset; one write of 0xA5 at edge k -> empty=0 and dout=0xA5 after edge k+2; count=1 from edge k.
REQ-037 Write 512 incrementing words -> full=1 at count=512; prog_full rises at count=496; 513th write dropped, overflow=1; drain returns 0..511 in order.
REQ-038 Fill to 100, then 1000 cycles of wr_en=rd_en=1 with random data -> count stays 100, output matches a scoreboard, pointers wrap at least once.
REQ-039 rd_en pulsed while empty, and simultaneous wr/rd into empty -> underflow=1, write accepted, count=1; err_clr -> underflow=0 next edge.
REQ-040 Fill to 300, pulse rst_n low for a fraction of a cycle mid-burst -> all outputs at reset values asynchronously, then normal operation from the 2nd edge after release.
REQ-041 DATA_W=32, PAR_W=4, DEPTH_LOG2=4, PROG_FULL_OFFSET=2, PROG_EMPTY_THRESH=3 -> prog_full at count 14, prog_empty deasserts at count 4, full at 16.

Source files
------------

// File: rtl/sync_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO: sync-read RAM, a prefetch stage and an output register.
// Status flags and count are registered and track the committed (accepted write/read) occupancy.
module sync_fwft_fifo #(
  parameter int unsigned DATA_W            = 128,
  parameter int unsigned PAR_W             = 16,
  parameter int unsigned DEPTH_LOG2        = 9,
  parameter int unsigned PROG_FULL_OFFSET  = 16,
  parameter int unsigned PROG_EMPTY_THRESH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     din,
  input  logic [PAR_W-1:0]      dinp,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [DATA_W-1:0]     dout,
  output logic [PAR_W-1:0]      doutp,
  output logic                  empty,
  output logic                  full,
  output logic                  prog_full,
  output logic                  prog_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned WORD_W = DATA_W + PAR_W;
  localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
  localparam int unsigned PF_LVL = DEPTH - PROG_FULL_OFFSET;

  logic                  ready_q;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      mem_cnt_q, mem_cnt_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  s1_vld_q, s1_vld_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  pfull_q, pfull_d;
  logic                  pempty_q, pempty_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  wr_acc, rd_acc, out_ld, s1_take;

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [WORD_W-1:0]     ram_rd_q;
  logic [WORD_W-1:0]     out_q;

  // Requests are only honoured once the release of rst_n has been seen on an edge.
  assign wr_acc  = ready_q & wr_en & ~full_q;
  assign rd_acc  = ready_q & rd_en & ~empty_q;
  assign out_ld  = s1_vld_q & (empty_q | rd_acc);
  assign s1_take = (mem_cnt_q != '0) & (~s1_vld_q | out_ld);

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    mem_cnt_d = mem_cnt_q;
    count_d   = count_q;
    s1_vld_d  = s1_vld_q;
    empty_d   = empty_q;

    if (wr_acc)  wptr_d = wptr_q + DEPTH_LOG2'(1);
    if (s1_take) rptr_d = rptr_q + DEPTH_LOG2'(1);
    mem_cnt_d = mem_cnt_q + CNT_W'(wr_acc) - CNT_W'(s1_take);

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    s1_vld_d = s1_take | (s1_vld_q & ~out_ld);
    empty_d  = ~(out_ld | (~empty_q & ~rd_acc));

    full_d   = (count_d == CNT_W'(DEPTH));
    pfull_d  = (count_d >= CNT_W'(PF_LVL));
    pempty_d = (count_d <= CNT_W'(PROG_EMPTY_THRESH));

    // A new error event wins over a clear in the same cycle.
    ovf_d = (ready_q & wr_en & full_q)  | (ovf_q & ~err_clr);
    udf_d = (ready_q & rd_en & empty_q) | (udf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      mem_cnt_q <= '0;
      count_q   <= '0;
      s1_vld_q  <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      pfull_q   <= 1'b0;
      pempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      ready_q   <= 1'b1;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      mem_cnt_q <= mem_cnt_d;
      count_q   <= count_d;
      s1_vld_q  <= s1_vld_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      pfull_q   <= pfull_d;
      pempty_q  <= pempty_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Data path carries no reset; validity is tracked by the control flops above.
  always_ff @(posedge clk) begin
    if (wr_acc)  mem[wptr_q] <= {dinp, din};
    if (s1_take) ram_rd_q    <= mem[rptr_q];
    if (out_ld)  out_q       <= ram_rd_q;
  end

  assign dout       = out_q[DATA_W-1:0];
  assign doutp      = out_q[WORD_W-1:DATA_W];
  assign empty      = empty_q;
  assign full       = full_q;
  assign prog_full  = pfull_q;
  assign prog_empty = pempty_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule

// File: tb/tb_sync_fwft_fifo.sv
// Directed bench for sync_fwft_fifo: default configuration plus a 16-deep instance for flag thresholds.
module tb_sync_fwft_fifo;

  logic clk, rst_n;

  logic [127:0] a_din, a_dout;
  logic [15:0]  a_dinp, a_doutp;
  logic         a_wr, a_rd, a_clr;
  logic         a_empty, a_full, a_pf, a_pe, a_ovf, a_udf;
  logic [9:0]   a_count;

  logic [31:0]  b_din, b_dout;
  logic [3:0]   b_dinp, b_doutp;
  logic         b_wr, b_rd, b_clr;
  logic         b_empty, b_full, b_pf, b_pe, b_ovf, b_udf;
  logic [4:0]   b_count;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fwft_fifo u_dut_a (
    .clk(clk), .rst_n(rst_n), .din(a_din), .dinp(a_dinp), .wr_en(a_wr), .rd_en(a_rd),
    .err_clr(a_clr), .dout(a_dout), .doutp(a_doutp), .empty(a_empty), .full(a_full),
    .prog_full(a_pf), .prog_empty(a_pe), .count(a_count), .overflow(a_ovf), .underflow(a_udf)
  );

  sync_fwft_fifo #(
    .DATA_W(32), .PAR_W(4), .DEPTH_LOG2(4), .PROG_FULL_OFFSET(2), .PROG_EMPTY_THRESH(3)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .din(b_din), .dinp(b_dinp), .wr_en(b_wr), .rd_en(b_rd),
    .err_clr(b_clr), .dout(b_dout), .doutp(b_doutp), .empty(b_empty), .full(b_full),
    .prog_full(b_pf), .prog_empty(b_pe), .count(b_count), .overflow(b_ovf), .underflow(b_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [143:0] sb[$];
    logic [143:0] w;
    int k;

    rst_n = 1'b1;
    a_din = '0; a_dinp = '0; a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;
    b_din = '0; b_dinp = '0; b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    check("rst_pf", a_pf, 0);
    check("rst_pe", a_pe, 1);
    check("rst_count", a_count, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_udf", a_udf, 0);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();

    // Single write latency
    a_wr = 1'b1; a_din = 128'hA5; a_dinp = 16'h5;
    tick();
    a_wr = 1'b0;
    check("k_count", a_count, 1);
    check("k_empty", a_empty, 1);
    tick();
    check("k1_empty", a_empty, 1);
    tick();
    check("k2_empty", a_empty, 0);
    check("k2_dout", {a_doutp, a_dout}, {16'h5, 128'hA5});
    tick();
    check("hold_dout", a_dout, 128'hA5);
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    check("pop_count", a_count, 0);
    check("pop_empty", a_empty, 1);
    check("pop_udf", a_udf, 0);

    // Fill to full with flag thresholds
    for (int i = 0; i < 512; i++) begin
      a_wr = 1'b1; a_din = 128'(i); a_dinp = 16'(i);
      tick();
      if (i == 15)  check("pe_at16", a_pe, 1);
      if (i == 16)  check("pe_at17", a_pe, 0);
      if (i == 494) check("pf_at495", a_pf, 0);
      if (i == 495) check("pf_at496", a_pf, 1);
      if (i == 510) check("full_at511", a_full, 0);
      if (i == 511) begin
        check("full_at512", a_full, 1);
        check("count_512", a_count, 512);
      end
    end
    a_din = 128'd999; a_rd = 1'b1;
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    check("ovf_set", a_ovf, 1);
    check("ovf_count", a_count, 511);
    check("ovf_full", a_full, 0);
    for (int i = 1; i < 512; i++) begin
      check("drain", {a_doutp, a_dout}, {16'(i), 128'(i)});
      a_rd = 1'b1;
      tick();
    end
    a_rd = 1'b0;
    check("drain_empty", a_empty, 1);
    check("drain_count", a_count, 0);
    check("drain_udf", a_udf, 0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("ovf_clr", a_ovf, 0);

    // Steady state at 100 words with wrapping pointers
    for (int i = 0; i < 100; i++) begin
      a_wr = 1'b1; a_din = 128'(1000 + i); a_dinp = 16'(i + 7);
      sb.push_back({a_dinp, a_din});
      tick();
    end
    a_wr = 1'b0;
    tick(); tick(); tick();
    check("fill100", a_count, 100);
    for (int c = 0; c < 1000; c++) begin
      a_din = {$urandom, $urandom, $urandom, $urandom};
      a_dinp = 16'($urandom);
      a_wr = 1'b1; a_rd = 1'b1;
      check("steady", {a_doutp, a_dout}, sb[0]);
      w = sb.pop_front();
      sb.push_back({a_dinp, a_din});
      tick();
    end
    a_wr = 1'b0; a_rd = 1'b0;
    check("steady_count", a_count, 100);
    while (sb.size() > 0) begin
      w = sb.pop_front();
      check("sb_drain", {a_doutp, a_dout}, w);
      a_rd = 1'b1;
      tick();
    end
    a_rd = 1'b0;
    check("sb_empty", a_empty, 1);

    // Underflow and error clear priority
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    check("udf_set", a_udf, 1);
    check("udf_count", a_count, 0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("udf_clr", a_udf, 0);
    a_wr = 1'b1; a_rd = 1'b1; a_din = 128'd5; a_dinp = 16'd1;
    tick();
    a_wr = 1'b0; a_clr = 1'b1;
    check("wr_rd_udf", a_udf, 1);
    check("wr_rd_count", a_count, 1);
    tick();
    a_rd = 1'b0;
    check("clr_prio", a_udf, 1);
    check("clr_prio_count", a_count, 1);
    tick();
    a_clr = 1'b0;
    check("udf_clr2", a_udf, 0);
    check("wr_rd_empty", a_empty, 0);
    check("wr_rd_dout", a_dout, 128'd5);
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    check("wr_rd_pop", a_count, 0);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 300; i++) begin
      a_wr = 1'b1; a_din = 128'(i); a_dinp = 16'(i);
      tick();
    end
    check("pre_rst_count", a_count, 300);
    a_din = 128'd77; a_dinp = 16'd3;
    rst_n = 1'b0;
    #1;
    check("arst_empty", a_empty, 1);
    check("arst_count", a_count, 0);
    check("arst_pe", a_pe, 1);
    check("arst_pf", a_pf, 0);
    check("arst_full", a_full, 0);
    #1 rst_n = 1'b1;
    tick();
    check("rel_edge1", a_count, 0);
    tick();
    check("rel_edge2", a_count, 1);
    a_wr = 1'b0;
    tick();
    check("rel_empty", a_empty, 1);
    tick();
    check("rel_dout", {a_doutp, a_dout}, {16'd3, 128'd77});
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    check("rel_pop", a_count, 0);

    // Small configuration thresholds
    for (int i = 0; i < 16; i++) begin
      b_wr = 1'b1; b_din = 32'(i + 100); b_dinp = 4'(i);
      tick();
      k = i + 1;
      check("b_pe", b_pe, (k <= 3));
      check("b_pf", b_pf, (k >= 14));
      check("b_full", b_full, (k == 16));
      check("b_count", b_count, k);
    end
    b_din = 32'hDEAD;
    tick();
    b_wr = 1'b0;
    check("b_ovf", b_ovf, 1);
    check("b_ovf_count", b_count, 16);
    for (int i = 0; i < 16; i++) begin
      check("b_drain", {b_doutp, b_dout}, {4'(i), 32'(i + 100)});
      b_rd = 1'b1;
      tick();
    end
    b_rd = 1'b0;
    check("b_empty", b_empty, 1);
    check("b_udf", b_udf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
